// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline interlock: control-hazard FSM encoding,
// in-flight write limit and the width of the DE-to-FE stall bus.
package pipe_ctrl_pkg;

    typedef enum logic [0:0] {
        SB_IDLE    = 1'b0,
        SB_WAIT_BR = 1'b1
    } sb_state_e;

    localparam int unsigned MAX_INFLIGHT  = 3;
    localparam int unsigned FE_STALL_BITS = 1;

endpackage

// File: rtl/reg_busy_counter.sv
// Saturating up/down counter of outstanding writes to one architectural register.
// Reports nonzero / exactly-one, plus a one-cycle error on overflow or underflow.
module reg_busy_counter #(
    parameter int unsigned CNTBITS = 2,
    parameter int unsigned MAX_CNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic inc,
    input  logic dec,
    output logic nonzero,
    output logic is_one,
    output logic err
);

    localparam logic [CNTBITS-1:0] MaxVal = CNTBITS'(MAX_CNT);

    logic [CNTBITS-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        err   = 1'b0;
        unique case ({inc, dec})
            2'b10: begin
                if (cnt_q == MaxVal) err = 1'b1;
                else                 cnt_d = cnt_q + 1'b1;
            end
            2'b01: begin
                if (cnt_q == '0) err = 1'b1;
                else             cnt_d = cnt_q - 1'b1;
            end
            // Simultaneous inc and dec cancel out.
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign nonzero = (cnt_q != '0);
    assign is_one  = (cnt_q == CNTBITS'(1));

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline interlock: tracks in-flight register/CSR writes between DE and WB,
// stalls DE on RAW hazards and holds FE while a control instruction is unresolved.
module hazard_scoreboard #(
    parameter int unsigned REGNOBITS    = 5,
    parameter int unsigned MAX_INFLIGHT = pipe_ctrl_pkg::MAX_INFLIGHT,
    parameter int unsigned CNTBITS      = 2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   de_valid,
    input  logic [REGNOBITS-1:0]                   de_rs1,
    input  logic [REGNOBITS-1:0]                   de_rs2,
    input  logic                                   de_rs1_used,
    input  logic                                   de_rs2_used,
    input  logic [REGNOBITS-1:0]                   de_rd,
    input  logic                                   de_wr_reg,
    input  logic                                   de_rd_csr,
    input  logic                                   de_wr_csr,
    input  logic                                   de_is_ctrl,
    input  logic                                   wb_wr_reg,
    input  logic [REGNOBITS-1:0]                   wb_regno,
    input  logic                                   wb_wr_csr,
    input  logic                                   agex_br_resolved,
    output logic                                   stall_de,
    output logic [pipe_ctrl_pkg::FE_STALL_BITS-1:0] stall_fe,
    output logic                                   issue,
    output logic [31:0]                            busy_mask,
    output logic                                   sb_error
);

    import pipe_ctrl_pkg::*;

    localparam int unsigned NREGS = 2 ** REGNOBITS;

    sb_state_e state_q, state_d;

    logic [NREGS-1:0] reg_nz, reg_one, reg_err;
    logic             csr_nz, csr_one, csr_err;
    logic             reg_inc, csr_inc;
    logic             rs1_hz, rs2_hz, csr_hz, raw_hz;
    logic             sb_error_q;

    assign reg_inc = issue & de_wr_reg;
    assign csr_inc = issue & de_wr_csr;

    // x0 is hardwired zero and never tracked.
    assign reg_nz[0]  = 1'b0;
    assign reg_one[0] = 1'b0;
    assign reg_err[0] = 1'b0;

    for (genvar i = 1; i < NREGS; i++) begin : g_reg
        reg_busy_counter #(
            .CNTBITS (CNTBITS),
            .MAX_CNT (MAX_INFLIGHT)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .inc     (reg_inc & (de_rd == REGNOBITS'(i))),
            .dec     (wb_wr_reg & (wb_regno == REGNOBITS'(i))),
            .nonzero (reg_nz[i]),
            .is_one  (reg_one[i]),
            .err     (reg_err[i])
        );
    end

    reg_busy_counter #(
        .CNTBITS (CNTBITS),
        .MAX_CNT (MAX_INFLIGHT)
    ) u_csr_cnt (
        .clk     (clk),
        .reset   (reset),
        .inc     (csr_inc),
        .dec     (wb_wr_csr),
        .nonzero (csr_nz),
        .is_one  (csr_one),
        .err     (csr_err)
    );

    // A last outstanding write retiring this cycle does not stall: the register
    // file writes on negedge so DE already sees the new value.
    assign rs1_hz = de_rs1_used & (de_rs1 != '0) & reg_nz[de_rs1]
                  & ~(reg_one[de_rs1] & wb_wr_reg & (wb_regno == de_rs1));
    assign rs2_hz = de_rs2_used & (de_rs2 != '0) & reg_nz[de_rs2]
                  & ~(reg_one[de_rs2] & wb_wr_reg & (wb_regno == de_rs2));
    assign csr_hz = de_rd_csr & csr_nz;
    assign raw_hz = de_valid & (rs1_hz | rs2_hz | csr_hz);

    always_comb begin
        stall_de = raw_hz | (state_q == SB_WAIT_BR);
        issue    = de_valid & ~stall_de;
        stall_fe = {FE_STALL_BITS{(de_valid & de_is_ctrl) | (state_q == SB_WAIT_BR) | stall_de}};
        state_d  = state_q;
        unique case (state_q)
            SB_IDLE:    if (issue & de_is_ctrl) state_d = SB_WAIT_BR;
            SB_WAIT_BR: if (agex_br_resolved)   state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SB_IDLE;
            sb_error_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sb_error_q <= sb_error_q | (|reg_err) | csr_err;
        end
    end

    assign busy_mask = 32'(reg_nz);
    assign sb_error  = sb_error_q;

    logic unused_csr_one;
    assign unused_csr_one = csr_one;

endmodule
